mem_arbiter: RTL and testbench

Sequencer and arbiter for the single-ported unified memory. It shares the port between instruction fetch (IF stage) and data access driven by the EX/MEM pipeline register (MemRead/MemWrite, ALU-result address, store data). It issues one access at a time and waits on the memory's completion handshake. It returns read data with one-cycle ready pulses, produces the pipeline stall signals, and honours HALT.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and data access.
// One access in flight at a time; fixed data priority with fetch anti-starvation.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              halt_in,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              halted,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE, IACC, DACC, HALTED
  } state_t;

  state_t      state;
  logic        last_d;
  logic [7:0]  cnt;
  logic        if_cand;
  logic        d_cand;
  logic        grant_d;
  logic        grant_i;
  logic        done;
  logic [DATA_W-1:0] rdata_c;

  assign stall_fetch = if_req & ~if_ready;
  assign stall_mem   = (d_read | d_write) & ~d_ready;

  // a requester whose ready pulse is high has just been served
  assign if_cand = if_req & ~if_ready;
  assign d_cand  = (d_read | d_write) & ~d_ready;
  assign grant_d = d_cand & ~(last_d & if_cand);
  assign grant_i = if_cand & ~grant_d;

  assign done    = mem_rdy | (cnt == 8'(TIMEOUT));
  assign rdata_c = mem_rdy ? mem_rdata : '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      cnt       <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (halt_in) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (grant_d) begin
            state     <= DACC;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_we    <= d_write;
            mem_re    <= ~d_write;
            last_d    <= 1'b1;
            cnt       <= '0;
          end else if (grant_i) begin
            state    <= IACC;
            mem_addr <= if_addr;
            mem_re   <= 1'b1;
            mem_we   <= 1'b0;
            last_d   <= 1'b0;
            cnt      <= '0;
          end
        end
        IACC, DACC: begin
          if (done) begin
            if (state == IACC) begin
              if_rdata <= rdata_c;
              if_ready <= 1'b1;
            end else begin
              if (mem_re) d_rdata <= rdata_c;
              d_ready <= 1'b1;
            end
            if (!mem_rdy) err <= 1'b1;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HALTED: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ready;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        halt_in;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rdy;
  logic        stall_fetch;
  logic        stall_mem;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ready    (if_ready),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ready     (d_ready),
    .halt_in     (halt_in),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rdy     (mem_rdy),
    .stall_fetch (stall_fetch),
    .stall_mem   (stall_mem),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1 (tag, mem_re, 1'b0);
    chk1 (tag, mem_we, 1'b0);
    chk16(tag, mem_addr, 16'h0);
    chk16(tag, mem_wdata, 16'h0);
    chk16(tag, if_rdata, 16'h0);
    chk16(tag, d_rdata, 16'h0);
    chk1 (tag, if_ready, 1'b0);
    chk1 (tag, d_ready, 1'b0);
    chk1 (tag, halted, 1'b0);
    chk1 (tag, err, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    halt_in = 0; mem_rdata = '0; mem_rdy = 0;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // single load
    d_read = 1; d_addr = 16'h0040;
    #1 chk1("ld_stall_n", stall_mem, 1'b1);
    tick();
    chk1 ("ld_re", mem_re, 1'b1);
    chk16("ld_addr", mem_addr, 16'h0040);
    chk1 ("ld_stall_n1", stall_mem, 1'b1);
    chk1 ("ld_rdy_early", d_ready, 1'b0);
    mem_rdy = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_rdy = 0;
    chk1 ("ld_ready", d_ready, 1'b1);
    chk16("ld_rdata", d_rdata, 16'hBEEF);
    chk1 ("ld_stall_n2", stall_mem, 1'b0);
    chk1 ("ld_re_off", mem_re, 1'b0);
    d_read = 0;
    tick();
    chk1("ld_pulse", d_ready, 1'b0);
    chk1("ld_no_regrant", mem_re, 1'b0);

    // store with 3-cycle memory
    d_write = 1; d_addr = 16'h0010; d_wdata = 16'h1234;
    tick();
    chk1 ("st_we1", mem_we, 1'b1);
    chk1 ("st_re", mem_re, 1'b0);
    chk16("st_wdata1", mem_wdata, 16'h1234);
    chk16("st_addr", mem_addr, 16'h0010);
    tick();
    chk1 ("st_we2", mem_we, 1'b1);
    chk16("st_wdata2", mem_wdata, 16'h1234);
    tick();
    chk1 ("st_we3", mem_we, 1'b1);
    chk16("st_wdata3", mem_wdata, 16'h1234);
    chk1 ("st_rdy_early", d_ready, 1'b0);
    mem_rdy = 1; mem_rdata = 16'h9999;
    tick();
    mem_rdy = 0;
    chk1 ("st_ready", d_ready, 1'b1);
    chk16("st_rdata_keep", d_rdata, 16'hBEEF);
    chk1 ("st_we_off", mem_we, 1'b0);
    d_write = 0;
    tick();
    chk1("st_pulse", d_ready, 1'b0);

    // contention from reset: data first, fetch in data ready cycle
    rst = 1; tick(); rst = 0;
    if_req = 1; if_addr = 16'h0100;
    d_read = 1; d_addr = 16'h0200;
    tick();
    chk16("ct_d_first", mem_addr, 16'h0200);
    chk1 ("ct_re1", mem_re, 1'b1);
    chk1 ("ct_stall_f", stall_fetch, 1'b1);
    mem_rdy = 1; mem_rdata = 16'hAAAA;
    tick();
    mem_rdy = 0;
    chk1 ("ct_d_ready", d_ready, 1'b1);
    chk16("ct_d_rdata", d_rdata, 16'hAAAA);
    d_read = 0;
    tick();
    chk1 ("ct_f_re", mem_re, 1'b1);
    chk16("ct_f_addr", mem_addr, 16'h0100);
    mem_rdy = 1; mem_rdata = 16'h5555;
    tick();
    mem_rdy = 0;
    chk1 ("ct_if_ready", if_ready, 1'b1);
    chk16("ct_if_rdata", if_rdata, 16'h5555);
    chk1 ("ct_stall_f0", stall_fetch, 1'b0);
    if_req = 0;
    tick();
    // lone data access so last grant is data
    d_read = 1; d_addr = 16'h0300;
    tick();
    chk16("ct_d2_addr", mem_addr, 16'h0300);
    mem_rdy = 1; mem_rdata = 16'h1111;
    tick();
    mem_rdy = 0;
    chk1("ct_d2_ready", d_ready, 1'b1);
    d_read = 0;
    tick();
    if_req = 1; if_addr = 16'h0104;
    d_read = 1; d_addr = 16'h0304;
    tick();
    chk16("ct_f_first", mem_addr, 16'h0104);
    mem_rdy = 1; mem_rdata = 16'h2222;
    tick();
    mem_rdy = 0;
    chk1("ct_f2_ready", if_ready, 1'b1);
    if_req = 0;
    tick();
    chk16("ct_d3_addr", mem_addr, 16'h0304);
    chk1 ("ct_d3_re", mem_re, 1'b1);
    mem_rdy = 1; mem_rdata = 16'h3333;
    tick();
    mem_rdy = 0;
    chk16("ct_d3_rdata", d_rdata, 16'h3333);
    d_read = 0;
    tick();

    // timeout on fetch
    if_req = 1; if_addr = 16'h0500;
    tick();
    chk1("to_re", mem_re, 1'b1);
    repeat (255) tick();
    chk1("to_re_last", mem_re, 1'b1);
    chk1("to_no_ready", if_ready, 1'b0);
    chk1("to_no_err", err, 1'b0);
    tick();
    chk1 ("to_ready", if_ready, 1'b1);
    chk16("to_rdata", if_rdata, 16'hFFFF);
    chk1 ("to_err", err, 1'b1);
    chk1 ("to_re_off", mem_re, 1'b0);
    if_req = 0;
    tick();
    chk1("to_pulse", if_ready, 1'b0);
    chk1("to_sticky", err, 1'b1);

    // halt during data access
    d_read = 1; d_addr = 16'h0600;
    tick();
    chk1("h_re", mem_re, 1'b1);
    halt_in = 1;
    tick();
    chk1("h_re_held", mem_re, 1'b1);
    chk1("h_not_yet", halted, 1'b0);
    mem_rdy = 1; mem_rdata = 16'h7777;
    tick();
    mem_rdy = 0;
    chk1 ("h_d_ready", d_ready, 1'b1);
    chk16("h_d_rdata", d_rdata, 16'h7777);
    d_read = 0;
    tick();
    chk1("h_halted", halted, 1'b1);
    halt_in = 0;
    if_req = 1; if_addr = 16'h0800;
    repeat (4) begin
      tick();
      chk1("h_no_re", mem_re, 1'b0);
      chk1("h_no_ready", if_ready, 1'b0);
      chk1("h_stay", halted, 1'b1);
    end
    if_req = 0;

    // reset during fetch access
    rst = 1; tick(); rst = 0;
    if_req = 1; if_addr = 16'h0700;
    tick();
    chk1 ("rm_re", mem_re, 1'b1);
    chk16("rm_addr", mem_addr, 16'h0700);
    rst = 1;
    #1 chk_zero("rm_async");
    tick();
    rst = 0; if_req = 0;
    mem_rdy = 1; mem_rdata = 16'hDEAD;
    tick();
    mem_rdy = 0;
    chk1 ("rm_stray", if_ready, 1'b0);
    chk16("rm_rdata", if_rdata, 16'h0);
    tick();
    chk1("rm_stray2", if_ready, 1'b0);
    chk1("rm_idle", mem_re, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
